jump_ctrl: RTL
==============

Name: jump_ctrl

Overview:
- Upstream driver of the ball-bounce offset stage: turns a raw push-button into the `jump` step strobe that the bounce stage consumes.
- Contains:
  - a 2-FF synchroniser and debouncer;
  - a jump FSM that emits exactly JUMP_STEPS one-cycle strobes, spaced STEP_DIV cycles apart;
  - re-arm logic, so each physical press produces exactly one jump.
- The downstream offset stage has no reset, so top level must hold it consistent with this block's `rst`.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required before the debounced key changes; minimum 1.
- STEP_DIV, 1000000: clock cycles between successive jump strobes; minimum 2.
- JUMP_STEPS, 8: strobes per jump (first half rise, second half fall downstream); range 1..15.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- key_in  input  1  raw asynchronous button, active-high
- jump  output  1  one-cycle step strobe to the bounce stage
- busy  output  1  high while a jump is in progress
- step_idx  output  4  number of strobes already issued in the current jump (0..JUMP_STEPS)
- landed  output  1  one-cycle pulse when a jump completes

Behaviour:
- One clock: clk. Reset is synchronous and active-high (`rst`), sampled on posedge clk.
- Reset values:
  - jump=0, busy=0, step_idx=0, landed=0;
  - FSM=IDLE, sync FFs=0, debounced key=0;
  - debounce counter=0, step divider=0.
- Reset applied mid-jump aborts the jump immediately. No further strobes are issued, and `landed` is not pulsed.
- Synchroniser: key_in passes through 2 FFs to give key_s.
- Debounce:
  - counter increments while key_s != key_db, and clears to 0 whenever key_s == key_db;
  - when the counter reaches DEBOUNCE_CYCLES-1 with key_s still != key_db, key_db <= key_s and the counter clears;
  - glitches shorter than DEBOUNCE_CYCLES cycles never reach key_db.
- press = key_db rising edge, a one-cycle internal signal in the cycle after key_db goes high.
- FSM states:
  - IDLE: if press, go to RUN. On entry to RUN, load divider = STEP_DIV-1, step_idx=0, busy=1.
  - RUN:
    - divider counts down by 1 per cycle;
    - when divider==0: jump=1 for that cycle, step_idx increments, divider reloads STEP_DIV-1;
    - the strobe that brings step_idx to JUMP_STEPS is the last; the next cycle goes to WAIT_RELEASE with landed=1 for that one cycle and busy=0.
  - WAIT_RELEASE: go to IDLE once key_db==0. step_idx holds JUMP_STEPS until the next RUN entry clears it.
- Timing:
  - first strobe occurs exactly STEP_DIV cycles after the press cycle;
  - strobes are exactly STEP_DIV cycles apart;
  - total jump duration is JUMP_STEPS*STEP_DIV cycles.
- Press handling:
  - a press while in RUN is ignored, with no buffering;
  - a key held through the whole jump does not re-trigger; it must be released (debounced) first.
- Release and re-press inside one debounce window: the press is filtered; no event.
- jump is never high in two consecutive cycles (STEP_DIV>=2).
- Counter widths: $clog2 of each parameter, computed in the package. No wrap is possible, because the counters reload before overflow.

Decomposition:
- Package jump_pkg holds:
  - state enum {IDLE, RUN, WAIT_RELEASE};
  - default constants for DEBOUNCE_CYCLES, STEP_DIV and JUMP_STEPS;
  - width helper constants.
- One natural sub-module, key_debounce (synchroniser plus debounce counter; outputs key_db). It is reusable for other buttons. The FSM and divider stay in jump_ctrl.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, STEP_DIV=3, JUMP_STEPS=8.
- Clean press: key_in high for 100 cycles, from reset.
  - press occurs 2+4+1 cycles after the key_in edge;
  - jump pulses at press+3, +6, ... +24 (8 pulses total);
  - landed at press+25; busy high press+1..press+24; step_idx ends at 8.
- Glitch rejection: key_in high for 3 cycles, then low.
  - no press, no jump, busy stays 0.
- Held key: key_in held high for 200 cycles.
  - exactly 8 jump pulses, then WAIT_RELEASE;
  - release then re-press gives a second jump of 8 pulses.
- Press during RUN: second debounced press at press+10.
  - still exactly 8 pulses in the original timing; no extra jump.
- Reset mid-jump: rst high for 1 cycle after the 3rd strobe.
  - next cycle all outputs 0, no further pulses, no landed;
  - a fresh press then produces a full 8-pulse jump.

Source files
------------

// File: rtl/jump_pkg.sv
// jump_pkg: shared states, default parameters and width helpers for jump_ctrl.
package jump_pkg;

   typedef enum logic [1:0] {IDLE, RUN, WAIT_RELEASE} state_e;

   localparam int DEBOUNCE_CYCLES_DEF = 500000;
   localparam int STEP_DIV_DEF        = 1000000;
   localparam int JUMP_STEPS_DEF      = 8;
   localparam int STEP_W              = 4;

   // Counter width for a modulus n; never narrower than one bit.
   function automatic int cw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DB_W_DEF  = cw(DEBOUNCE_CYCLES_DEF);
   localparam int DIV_W_DEF = cw(STEP_DIV_DEF);

endpackage

// File: rtl/jump_ctrl_key_debounce.sv
// key_debounce: 2-FF synchroniser plus stable-count debouncer for one button.
module key_debounce
   import jump_pkg::*;
#(
   parameter int CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic key_in,
   output logic key_db
);

   localparam int W = cw(CYCLES);

   logic         s1_q, s1_d, s2_q, s2_d, db_q, db_d;
   logic [W-1:0] cnt_q, cnt_d;
   logic         diff, hit;

   always_comb begin
      s1_d  = key_in;
      s2_d  = s1_q;
      diff  = s2_q != db_q;
      hit   = diff && (cnt_q == W'(CYCLES - 1));
      cnt_d = (diff && !hit) ? cnt_q + W'(1) : '0;
      db_d  = hit ? s2_q : db_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q  <= 1'b0;
         s2_q  <= 1'b0;
         db_q  <= 1'b0;
         cnt_q <= '0;
      end else begin
         s1_q  <= s1_d;
         s2_q  <= s2_d;
         db_q  <= db_d;
         cnt_q <= cnt_d;
      end
   end

   assign key_db = db_q;

endmodule

// File: rtl/jump_ctrl.sv
// jump_ctrl: turns a debounced button press into JUMP_STEPS jump strobes
// spaced STEP_DIV cycles apart, re-arming only after the key is released.
module jump_ctrl
   import jump_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int STEP_DIV        = STEP_DIV_DEF,
   parameter int JUMP_STEPS      = JUMP_STEPS_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_in,
   output logic        jump,
   output logic        busy,
   output logic [3:0]  step_idx,
   output logic        landed
);

   localparam int DIV_W = cw(STEP_DIV);

   logic              key_db;
   state_e            state_q, state_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic              db_prev_q, db_prev_d, press_q, press_d;
   logic              jump_q, jump_d, busy_q, busy_d, landed_q, landed_d;

   key_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .rst    (rst),
      .key_in (key_in),
      .key_db (key_db)
   );

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      step_d    = step_q;
      busy_d    = busy_q;
      jump_d    = 1'b0;
      landed_d  = 1'b0;
      db_prev_d = key_db;
      press_d   = key_db & ~db_prev_q;
      case (state_q)
         IDLE: if (press_q) begin
            state_d = RUN;
            div_d   = DIV_W'(STEP_DIV - 1);
            step_d  = '0;
            busy_d  = 1'b1;
         end
         // jump is registered, so it is raised as div steps 1 -> 0.
         RUN: if (div_q == '0) begin
            div_d  = DIV_W'(STEP_DIV - 1);
            step_d = step_q + STEP_W'(1);
            if (step_q == STEP_W'(JUMP_STEPS - 1)) begin
               state_d  = WAIT_RELEASE;
               landed_d = 1'b1;
               busy_d   = 1'b0;
            end
         end else begin
            div_d  = div_q - DIV_W'(1);
            jump_d = div_q == DIV_W'(1);
         end
         WAIT_RELEASE: state_d = key_db ? WAIT_RELEASE : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         div_q     <= '0;
         step_q    <= '0;
         db_prev_q <= 1'b0;
         press_q   <= 1'b0;
         jump_q    <= 1'b0;
         busy_q    <= 1'b0;
         landed_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         step_q    <= step_d;
         db_prev_q <= db_prev_d;
         press_q   <= press_d;
         jump_q    <= jump_d;
         busy_q    <= busy_d;
         landed_q  <= landed_d;
      end
   end

   assign jump     = jump_q;
   assign busy     = busy_q;
   assign step_idx = step_q;
   assign landed   = landed_q;

endmodule
